// File: rtl/cajero_param.sv
// cajero_param: parametrised ATM session controller (PIN check, deposit, withdrawal, balance query, timeout)
module cajero_param #(
  parameter int N_DIGITOS = 4,
  parameter int MAX_INTENTOS = 3,
  parameter int ANCHO_MONTO = 32,
  parameter int ANCHO_BALANCE = 64,
  parameter logic [ANCHO_BALANCE-1:0] BALANCE_INICIAL = '0,
  parameter logic [ANCHO_MONTO-1:0] LIMITE_RETIRO = '0,
  parameter int TIMEOUT_CICLOS = 64
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     TARJETA_RECIBIDA,
  input  logic [4*N_DIGITOS-1:0]   PIN,
  input  logic [3:0]               DIGITO,
  input  logic                     DIGITO_STB,
  input  logic [1:0]               TIPO_TRANS,
  input  logic                     TIPO_STB,
  input  logic [ANCHO_MONTO-1:0]   MONTO,
  input  logic                     MONTO_STB,
  output logic                     BALANCE_ACTUALIZADO,
  output logic                     ENTREGAR_DINERO,
  output logic                     FONDOS_INSUFICIENTES,
  output logic                     LIMITE_EXCEDIDO,
  output logic                     PIN_INCORRECTO,
  output logic                     ADVERTENCIA,
  output logic                     BLOQUEO,
  output logic                     TIEMPO_AGOTADO,
  output logic [ANCHO_BALANCE-1:0] BALANCE,
  output logic                     BALANCE_VALIDO
);
  localparam int PW = 4*N_DIGITOS;
  localparam int DW = $clog2(N_DIGITOS+1);
  localparam int FW = $clog2(MAX_INTENTOS+1);
  localparam logic [2:0] S_ESPERA = 3'd0, S_PIN = 3'd1, S_TRANS = 3'd2, S_DEP = 3'd3,
                         S_RET = 3'd4, S_FIN = 3'd5, S_BLOQ = 3'd6;
  logic [2:0] st;
  logic [PW-1:0] pin_lat, dig_sh, nxt_pin;
  logic [DW-1:0] dig_cnt;
  logic [FW-1:0] fails, fails_inc;
  logic [31:0] tmr;
  logic d_q, t_q, m_q, d_rise, t_rise, m_rise, activo, timeout;
  logic [ANCHO_BALANCE-1:0] monto_ext;
  logic [ANCHO_BALANCE:0] suma;
  always_comb begin
    d_rise = DIGITO_STB & ~d_q;
    t_rise = TIPO_STB & ~t_q;
    m_rise = MONTO_STB & ~m_q;
    activo = st == S_PIN || st == S_TRANS || st == S_DEP || st == S_RET;
    timeout = TIMEOUT_CICLOS != 0 && tmr == 32'(TIMEOUT_CICLOS - 1);
    nxt_pin = (dig_sh << 4) | PW'(DIGITO);
    fails_inc = fails + FW'(1);
    monto_ext = ANCHO_BALANCE'(MONTO);
    suma = {1'b0, BALANCE} + (ANCHO_BALANCE+1)'(MONTO);
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      st <= S_ESPERA;
      pin_lat <= '0;
      dig_sh <= '0;
      dig_cnt <= '0;
      fails <= '0;
      tmr <= '0;
      d_q <= 1'b0;
      t_q <= 1'b0;
      m_q <= 1'b0;
      BALANCE_ACTUALIZADO <= 1'b0;
      ENTREGAR_DINERO <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      LIMITE_EXCEDIDO <= 1'b0;
      PIN_INCORRECTO <= 1'b0;
      ADVERTENCIA <= 1'b0;
      BLOQUEO <= 1'b0;
      TIEMPO_AGOTADO <= 1'b0;
      BALANCE <= BALANCE_INICIAL;
      BALANCE_VALIDO <= 1'b0;
    end else begin
      d_q <= DIGITO_STB;
      t_q <= TIPO_STB;
      m_q <= MONTO_STB;
      BALANCE_ACTUALIZADO <= 1'b0;
      ENTREGAR_DINERO <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      LIMITE_EXCEDIDO <= 1'b0;
      PIN_INCORRECTO <= 1'b0;
      TIEMPO_AGOTADO <= 1'b0;
      BALANCE_VALIDO <= 1'b0;
      tmr <= activo ? tmr + 32'd1 : '0;
      if (activo && !TARJETA_RECIBIDA) begin
        st <= S_ESPERA;
        tmr <= '0;
      end else if (activo && timeout) begin
        TIEMPO_AGOTADO <= 1'b1;
        st <= S_FIN;
        tmr <= '0;
      end else begin
        case (st)
          S_ESPERA: if (TARJETA_RECIBIDA) begin
            pin_lat <= PIN;
            dig_sh <= '0;
            dig_cnt <= '0;
            st <= S_PIN;
          end
          S_PIN: if (d_rise) begin
            tmr <= '0;
            if (dig_cnt == DW'(N_DIGITOS - 1)) begin
              dig_cnt <= '0;
              if (nxt_pin == pin_lat) begin
                fails <= '0;
                ADVERTENCIA <= 1'b0;
                st <= S_TRANS;
              end else begin
                fails <= fails_inc;
                PIN_INCORRECTO <= 1'b1;
                if (fails_inc == FW'(MAX_INTENTOS)) begin
                  BLOQUEO <= 1'b1;
                  ADVERTENCIA <= 1'b0;
                  st <= S_BLOQ;
                end else if (fails_inc == FW'(MAX_INTENTOS - 1)) ADVERTENCIA <= 1'b1;
              end
            end else begin
              dig_cnt <= dig_cnt + DW'(1);
              dig_sh <= nxt_pin;
            end
          end
          S_TRANS: if (t_rise && TIPO_TRANS != 2'b11) begin
            tmr <= '0;
            st <= TIPO_TRANS == 2'b00 ? S_DEP : TIPO_TRANS == 2'b01 ? S_RET : S_FIN;
            BALANCE_VALIDO <= TIPO_TRANS == 2'b10;
          end
          S_DEP: if (m_rise) begin
            tmr <= '0;
            BALANCE <= suma[ANCHO_BALANCE] ? '1 : suma[ANCHO_BALANCE-1:0];
            BALANCE_ACTUALIZADO <= 1'b1;
            st <= S_FIN;
          end
          S_RET: if (m_rise) begin
            tmr <= '0;
            st <= S_FIN;
            if (LIMITE_RETIRO != '0 && MONTO > LIMITE_RETIRO) LIMITE_EXCEDIDO <= 1'b1;
            else if (monto_ext > BALANCE) FONDOS_INSUFICIENTES <= 1'b1;
            else begin
              BALANCE <= BALANCE - monto_ext;
              BALANCE_ACTUALIZADO <= 1'b1;
              ENTREGAR_DINERO <= 1'b1;
            end
          end
          S_FIN: if (!TARJETA_RECIBIDA) st <= S_ESPERA;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cajero_param.sv
// tb_cajero_param: randomized session-level checking of cajero_param against a transaction model
module tb_cajero_param;
  localparam logic [15:0] CARD_PIN = 16'h5916;
  localparam int INIT = 10000;
  localparam int LIM = 5000;
  localparam int TMO = 16;
  localparam int MAXB = (1 << 18) - 1;
  localparam logic [6:0] P_ACT = 7'b1000000, P_ENT = 7'b0100000, P_FON = 7'b0010000,
                         P_LIM = 7'b0001000, P_PIN = 7'b0000100, P_TMO = 7'b0000010,
                         P_BV = 7'b0000001;
  logic clk = 0, reset_n = 0, card = 0, dig_stb = 0, tipo_stb = 0, monto_stb = 0;
  logic [3:0] digito = 0;
  logic [1:0] tipo = 0;
  logic [15:0] monto = 0;
  logic bal_act, entregar, fondos, limite, pin_inc, adv, bloq, tiempo, bal_val;
  logic [17:0] balance;
  logic [6:0] pulses;
  int n_cmp = 0, n_err = 0;
  int m_bal = INIT, m_fails = 0;
  logic m_lock = 0;
  cajero_param #(
    .ANCHO_MONTO(16), .ANCHO_BALANCE(18), .BALANCE_INICIAL(18'(INIT)),
    .LIMITE_RETIRO(16'(LIM)), .TIMEOUT_CICLOS(TMO)
  ) dut (
    .Clk(clk), .Reset(reset_n), .TARJETA_RECIBIDA(card), .PIN(CARD_PIN),
    .DIGITO(digito), .DIGITO_STB(dig_stb), .TIPO_TRANS(tipo), .TIPO_STB(tipo_stb),
    .MONTO(monto), .MONTO_STB(monto_stb), .BALANCE_ACTUALIZADO(bal_act),
    .ENTREGAR_DINERO(entregar), .FONDOS_INSUFICIENTES(fondos), .LIMITE_EXCEDIDO(limite),
    .PIN_INCORRECTO(pin_inc), .ADVERTENCIA(adv), .BLOQUEO(bloq), .TIEMPO_AGOTADO(tiempo),
    .BALANCE(balance), .BALANCE_VALIDO(bal_val)
  );
  assign pulses = {bal_act, entregar, fondos, limite, pin_inc, tiempo, bal_val};
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic expect_out(string tag, logic [6:0] e);
    chk({tag, ":pulses"}, 64'(pulses), 64'(e));
    chk({tag, ":adv_bloq"}, {62'd0, adv, bloq}, {62'd0, !m_lock && m_fails == 2, m_lock});
    chk({tag, ":balance"}, 64'(balance), 64'(m_bal));
  endtask
  task automatic pulse_in(int which, int v, logic [6:0] e, string tag);
    case (which)
      0: begin digito = 4'(v); dig_stb = 1; end
      1: begin tipo = 2'(v); tipo_stb = 1; end
      default: begin monto = 16'(v); monto_stb = 1; end
    endcase
    step();
    expect_out(tag, e);
    dig_stb = 0;
    tipo_stb = 0;
    monto_stb = 0;
    step();
    expect_out({tag, "_end"}, '0);
  endtask
  task automatic do_reset();
    reset_n = 0;
    m_bal = INIT;
    m_fails = 0;
    m_lock = 0;
    step();
    expect_out("reset", '0);
    reset_n = 1;
  endtask
  task automatic card_in();
    card = 1;
    step();
    expect_out("card_in", '0);
  endtask
  task automatic card_out();
    card = 0;
    step();
    expect_out("card_out", '0);
  endtask
  task automatic enter_pin(logic [15:0] code, int n);
    logic [6:0] e;
    for (int i = n - 1; i >= 0; i--) begin
      e = '0;
      if (i == 0 && !m_lock) begin
        if (code == CARD_PIN) m_fails = 0;
        else begin
          m_fails++;
          e = P_PIN;
          if (m_fails == 3) m_lock = 1;
        end
      end
      pulse_in(0, int'(code[4*i+:4]), e, "digit");
    end
  endtask
  task automatic deposit(int m);
    pulse_in(1, 0, '0, "tipo_dep");
    m_bal = m_bal + m > MAXB ? MAXB : m_bal + m;
    pulse_in(2, m, P_ACT, "dep");
  endtask
  task automatic withdraw(int m);
    logic [6:0] e;
    pulse_in(1, 1, '0, "tipo_ret");
    if (m > LIM) e = P_LIM;
    else if (m > m_bal) e = P_FON;
    else begin
      m_bal -= m;
      e = P_ACT | P_ENT;
    end
    pulse_in(2, m, e, "ret");
  endtask
  task automatic sess(int op, int amt);
    card_in();
    enter_pin(CARD_PIN, 4);
    case (op)
      0: deposit(amt);
      1: withdraw(amt);
      2: pulse_in(1, 2, P_BV, "qry");
      3: begin pulse_in(1, 3, '0, "tipo_bad"); deposit(amt); end
      default: pulse_in(1, 0, '0, "tipo_abandon");
    endcase
    card_out();
  endtask
  function automatic logic [15:0] wrong_pin();
    logic [15:0] c;
    do c = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9))};
    while (c == CARD_PIN);
    return c;
  endfunction
  initial begin
    step();
    do_reset();
    sess(0, 10000);
    sess(1, 5001);
    sess(1, 5000);
    sess(2, 0);
    card_in();
    pulse_in(0, 5, '0, "partial");
    pulse_in(0, 9, '0, "partial");
    card_out();
    sess(2, 0);
    card_in();
    digito = 5;
    dig_stb = 1;
    repeat (3) begin
      step();
      expect_out("hold", '0);
    end
    dig_stb = 0;
    step();
    enter_pin(CARD_PIN, 3);
    pulse_in(1, 2, P_BV, "hold_qry");
    card_out();
    card_in();
    enter_pin(16'h6194, 4);
    card_out();
    card_in();
    enter_pin(16'h7195, 4);
    enter_pin(CARD_PIN, 4);
    deposit(8000);
    card_out();
    card_in();
    enter_pin(16'h4916, 4);
    enter_pin(16'h5917, 4);
    enter_pin(16'h5316, 4);
    enter_pin(CARD_PIN, 4);
    card_out();
    pulse_in(1, 2, '0, "locked_tipo");
    pulse_in(2, 100, '0, "locked_monto");
    do_reset();
    card_in();
    enter_pin(CARD_PIN, 4);
    pulse_in(1, 0, '0, "tipo_dep");
    do_reset();
    step();
    expect_out("post_reset", '0);
    pulse_in(2, 3000, '0, "monto_ignored");
    card_out();
    sess(1, 5000);
    sess(1, 5000);
    sess(1, 1);
    sess(0, 10000);
    sess(1, 6000);
    card_in();
    enter_pin(CARD_PIN, 4);
    for (int k = 2; k <= TMO; k++) begin
      step();
      expect_out("idle", k == TMO ? P_TMO : '0);
    end
    step();
    expect_out("tmo_end", '0);
    pulse_in(1, 2, '0, "fin_tipo");
    card_out();
    repeat (40) begin
      int op, w;
      w = $urandom_range(0, 2);
      card_in();
      repeat (w) enter_pin(wrong_pin(), 4);
      card_out();
      op = $urandom_range(0, 4);
      sess(op, op == 1 ? $urandom_range(0, 7000) : $urandom_range(0, 20000));
    end
    repeat (5) sess(0, 65535);
    sess(1, 5000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
